kecti3_chain_sched: RTL and testbench
=====================================

KECTI3_CHAIN_SCHED -- requirements
Module: kecti3_chain_sched

Interface
REQ-001 SHALL have parameter TMO_W, 16, width of the poll timeout counter.
REQ-002 SHALL have parameter TMO_MAX, 16'd8191, number of status polls before a job is aborted.
REQ-003 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset: rst, synchronous, active-high; clock clk.
REQ-005 SHALL have ports rq_valid[i], rq_ready[i] (i=0,1)  input/output  1 each  per-requester job handshake.
REQ-006 SHALL have ports rq_secn[i]  input  8  n in {16,24,32}; rq_chns[i]  input  8  CHNS value; rq_adrs6[i], rq_adrs7[i]  input  32 each  ADRS words 6 and 7.
REQ-007 SHALL have ports rsp_valid  output  1; rsp_ready  input  1; rsp_id  output  1  requester index; rsp_err  output  2  0 ok, 1 bad secn, 2 timeout.
REQ-008 SHALL have master ports m_sel  output  1; m_wen  output  4; m_addr  output  8; m_wdata  output  32; m_rdata  input  32; m_irq  input  1  toward the masked Keccak peripheral.
REQ-009 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-010 States: IDLE, WR_A6, WR_A7, WR_SECN, WR_CHNS, POLL_REQ, POLL_WAIT, RESP.
REQ-011 IDLE: if any rq_valid, grant round-robin (last-granted requester loses ties; after reset requester 0 wins ties); pulse rq_ready[g] for one cycle; latch job; next state WR_A6.
REQ-012 Latched secn not in {16,24,32} -> skip all bus writes, go to RESP with rsp_err=1.
REQ-013 WR_A6: one-cycle write m_sel=1, m_wen=4'hF, m_addr=158, m_wdata=adrs6; WR_A7: likewise addr 159, adrs7.
REQ-014 WR_SECN: write addr 242, m_wdata={24'b0,secn}; WR_CHNS: write addr 243, m_wdata={24'b0,chns}.
REQ-015 Latched chns==0 -> WR_CHNS skipped, go straight from WR_SECN to RESP with rsp_err=0.
REQ-016 POLL_REQ: read cycle m_sel=1, m_wen=0, m_addr=240; next state POLL_WAIT; poll counter increments.
REQ-017 POLL_WAIT: m_sel=0; sample m_rdata (one-cycle read latency); m_rdata[15:0]==0 -> RESP err 0; else poll counter==TMO_MAX -> RESP err 2; else POLL_REQ.
REQ-018 First POLL_REQ SHALL be the cycle directly after WR_CHNS; the peripheral reports nonzero status at that read.
REQ-019 Outside bus-access cycles m_sel=0, m_wen=0, m_addr=0, m_wdata=0.
REQ-020 RESP: rsp_valid=1 with stable rsp_id/rsp_err until rsp_ready sampled high; then IDLE; rsp_valid and rsp_ready high in same cycle completes the transfer.
REQ-021 m_irq SHALL be ignored for sequencing (status polling is authoritative).
REQ-022 New requests SHALL be held off (rq_ready=0) while busy; rq_valid deassertion before grant is legal and drops the request.
REQ-023 Poll counter SHALL clear on every grant and saturate at TMO_MAX, never wrapping.

Reset
REQ-024 rst SHALL force IDLE, rq_ready=0, rsp_valid=0, rsp_id=0, rsp_err=0, busy=0, all m_* outputs 0, poll counter 0, round-robin pointer to favour requester 0.
REQ-025 rst mid-job SHALL abandon the job without a response; no further bus cycle occurs in the reset cycle or after it.

Structure
REQ-026 Peripheral register addresses (ADRS=152, TRIG=240, SECN=242, CHNS=243) and rsp_err codes SHALL live in a shared package/header used by both peripheral and scheduler.
REQ-027 Round-robin grant logic SHALL be one sub-module, kecti3_rr_arb2.

Verification
REQ-028 Single job rq0 secn=16 chns=3, peripheral model busy 60 cycles -> writes 158,159,242,243 in consecutive cycles, rsp_id=0, rsp_err=0.
REQ-029 rq0 and rq1 valid together twice in a row -> grants 0 then 1 then 0 then 1.
REQ-030 rq1 secn=20 -> no m_sel cycle, rsp_err=1 within 3 cycles of grant.
REQ-031 Model never clears status, TMO_MAX=4 -> exactly 5 POLL_REQ reads, rsp_err=2.
REQ-032 chns=0 -> only 3 writes, rsp_err=0; rsp_ready held low 10 cycles -> rsp_valid stays high, fields stable.
REQ-033 rst asserted in POLL_WAIT -> next cycle IDLE, all outputs 0, subsequent job from rq1 completes normally.

Source files
------------

// File: rtl/kecti3_pkg.sv
// kecti3_pkg: register map, response codes and scheduler states shared by the
// masked Keccak peripheral and its chain scheduler.
package kecti3_pkg;
    localparam logic [7:0] ADRS   = 8'd152;
    localparam logic [7:0] TRIG   = 8'd240;
    localparam logic [7:0] SECN   = 8'd242;
    localparam logic [7:0] CHNS   = 8'd243;
    localparam logic [7:0] REG_A6 = ADRS + 8'd6;
    localparam logic [7:0] REG_A7 = ADRS + 8'd7;

    localparam logic [1:0] ERR_OK   = 2'd0;
    localparam logic [1:0] ERR_SECN = 2'd1;
    localparam logic [1:0] ERR_TMO  = 2'd2;

    typedef enum logic [2:0] {
        IDLE, WR_A6, WR_A7, WR_SECN, WR_CHNS, POLL_REQ, POLL_WAIT, RESP
    } state_t;

    function automatic logic secn_ok(input logic [7:0] n);
        return n == 8'd16 || n == 8'd24 || n == 8'd32;
    endfunction
endpackage

// File: rtl/kecti3_chain_sched_rr.sv
// kecti3_rr_arb2: two-way round-robin arbiter; the last granted requester loses ties.
module kecti3_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       take,
    output logic [1:0] gnt,
    output logic       idx
);
    logic pri;

    assign idx = &req ? pri : req[1];
    assign gnt = req == 2'b00 ? 2'b00 : (idx ? 2'b10 : 2'b01);

    always_ff @(posedge clk)
        if (rst) pri <= 1'b0;
        else if (take) pri <= ~idx;
endmodule

// File: rtl/kecti3_chain_sched.sv
// kecti3_chain_sched: arbitrates two job requesters and drives one Keccak chain job
// at a time through the peripheral register bus, polling status until done or timeout.
module kecti3_chain_sched
    import kecti3_pkg::*;
#(
    parameter int TMO_W = 16,
    parameter logic [TMO_W-1:0] TMO_MAX = 16'd8191
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       rq_valid,
    output logic [1:0]       rq_ready,
    input  logic [1:0][7:0]  rq_secn,
    input  logic [1:0][7:0]  rq_chns,
    input  logic [1:0][31:0] rq_adrs6,
    input  logic [1:0][31:0] rq_adrs7,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [1:0]       rsp_err,
    output logic             m_sel,
    output logic [3:0]       m_wen,
    output logic [7:0]       m_addr,
    output logic [31:0]      m_wdata,
    input  logic [31:0]      m_rdata,
    input  logic             m_irq,
    output logic             busy
);
    state_t           state;
    logic [1:0]       gnt;
    logic             g, grant, hit, unused_in;
    logic [7:0]       secn, chns;
    logic [31:0]      adrs7;
    logic [TMO_W-1:0] cnt;

    assign grant     = state == IDLE && |rq_valid && !rst;
    assign rq_ready  = grant ? gnt : 2'b00;
    assign busy      = state != IDLE;
    assign unused_in = ^{m_irq, m_rdata[31:16]};

    kecti3_rr_arb2 u_arb (.clk(clk), .rst(rst), .req(rq_valid), .take(grant), .gnt(gnt), .idx(g));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            {rsp_valid, rsp_id, rsp_err} <= '0;
            {m_sel, m_wen, m_addr, m_wdata} <= '0;
            {secn, chns, adrs7, cnt, hit} <= '0;
        end else begin
            {m_sel, m_wen, m_addr, m_wdata} <= '0;
            case (state)
                IDLE: if (grant) begin
                    rsp_id <= g;
                    secn   <= rq_secn[g];
                    chns   <= rq_chns[g];
                    adrs7  <= rq_adrs7[g];
                    cnt    <= '0;
                    hit    <= 1'b0;
                    if (secn_ok(rq_secn[g])) begin
                        state <= WR_A6;
                        {m_sel, m_wen, m_addr, m_wdata} <= {1'b1, 4'hF, REG_A6, rq_adrs6[g]};
                    end else begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= ERR_SECN;
                    end
                end
                WR_A6: begin
                    state <= WR_A7;
                    {m_sel, m_wen, m_addr, m_wdata} <= {1'b1, 4'hF, REG_A7, adrs7};
                end
                WR_A7: begin
                    state <= WR_SECN;
                    {m_sel, m_wen, m_addr, m_wdata} <= {1'b1, 4'hF, SECN, 24'b0, secn};
                end
                WR_SECN: if (chns == 8'd0) begin
                    state     <= RESP;
                    rsp_valid <= 1'b1;
                    rsp_err   <= ERR_OK;
                end else begin
                    state <= WR_CHNS;
                    {m_sel, m_wen, m_addr, m_wdata} <= {1'b1, 4'hF, CHNS, 24'b0, chns};
                end
                WR_CHNS: begin
                    state <= POLL_REQ;
                    {m_sel, m_addr} <= {1'b1, TRIG};
                end
                // hit marks a read issued after TMO_MAX earlier polls: that one is the last
                POLL_REQ: begin
                    state <= POLL_WAIT;
                    hit   <= cnt == TMO_MAX;
                    cnt   <= cnt == TMO_MAX ? cnt : cnt + 1'b1;
                end
                POLL_WAIT: if (m_rdata[15:0] == 16'd0 || hit) begin
                    state     <= RESP;
                    rsp_valid <= 1'b1;
                    rsp_err   <= m_rdata[15:0] == 16'd0 ? ERR_OK : ERR_TMO;
                end else begin
                    state <= POLL_REQ;
                    {m_sel, m_addr} <= {1'b1, TRIG};
                end
                RESP: if (rsp_ready) begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_kecti3_chain_sched.sv
// tb_kecti3_chain_sched: directed and randomized jobs against a peripheral model,
// with expected bus writes and responses derived from the job parameters.
module tb_kecti3_chain_sched;
    localparam int TMO = 40;

    logic clk = 1'b0, rst = 1'b1;
    logic [1:0] rq_valid = '0, rq_ready;
    logic [1:0][7:0] rq_secn = '0, rq_chns = '0;
    logic [1:0][31:0] rq_adrs6 = '0, rq_adrs7 = '0;
    logic rsp_valid, rsp_ready = 1'b0, rsp_id;
    logic [1:0] rsp_err;
    logic m_sel, m_irq = 1'b0, busy;
    logic [3:0] m_wen;
    logic [7:0] m_addr;
    logic [31:0] m_wdata, m_rdata = '0;

    int tests = 0, fails = 0, cyc = 0, bus_bad = 0, busy_cfg = 60, busy_left = 0;
    int wb = 0, rb = 0;
    bit never_clear = 1'b0;
    logic [7:0] wr_addr[$];
    logic [31:0] wr_data[$];
    int wr_cyc[$], rd_cyc[$];

    kecti3_chain_sched #(.TMO_W(16), .TMO_MAX(16'(TMO))) dut (
        .clk(clk), .rst(rst), .rq_valid(rq_valid), .rq_ready(rq_ready),
        .rq_secn(rq_secn), .rq_chns(rq_chns), .rq_adrs6(rq_adrs6), .rq_adrs7(rq_adrs7),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_err(rsp_err),
        .m_sel(m_sel), .m_wen(m_wen), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_irq(m_irq), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Peripheral: busy for busy_cfg cycles after CHNS is written, status read with one-cycle latency
    always @(posedge clk) begin
        if (m_sel && m_wen == 4'hF && m_addr == 8'd243) busy_left <= busy_cfg;
        else if (busy_left > 0) busy_left <= busy_left - 1;
        m_rdata <= {16'($urandom), (never_clear || busy_left > 0) ? 16'h0001 : 16'h0000};
        m_irq <= busy_left == 1;
    end

    always @(negedge clk) begin
        if (m_sel && m_wen == 4'hF) begin
            wr_addr.push_back(m_addr);
            wr_data.push_back(m_wdata);
            wr_cyc.push_back(cyc);
        end else if (m_sel && m_wen == 4'h0 && m_addr == 8'd240) rd_cyc.push_back(cyc);
        else if (m_sel || m_wen != 0 || m_addr != 0 || m_wdata != 0) bus_bad <= bus_bad + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    function automatic logic [39:0] exp_wr(int k, logic [7:0] sn, ch, logic [31:0] a6, a7);
        return k == 0 ? {8'd158, a6} : k == 1 ? {8'd159, a7} : k == 2 ? {8'd242, 24'd0, sn} : {8'd243, 24'd0, ch};
    endfunction

    function automatic int exp_nwr(logic [7:0] sn, ch);
        return !(sn inside {8'd16, 8'd24, 8'd32}) ? 0 : ch == 0 ? 3 : 4;
    endfunction

    function automatic logic [1:0] exp_err(logic [7:0] sn, ch, bit nc);
        return !(sn inside {8'd16, 8'd24, 8'd32}) ? 2'd1 : ch == 0 ? 2'd0 : nc ? 2'd2 : 2'd0;
    endfunction

    task automatic start_job(input int r, input logic [7:0] sn, ch, input logic [31:0] a6, a7,
                             output int gc, output bit ok);
        wb = wr_addr.size();
        rb = rd_cyc.size();
        rq_secn[r] = sn; rq_chns[r] = ch; rq_adrs6[r] = a6; rq_adrs7[r] = a7;
        rq_valid[r] = 1'b1;
        #1;
        ok = 1'b0; gc = 0;
        for (int i = 0; i < 100; i++) begin
            if (rq_ready[r]) begin ok = 1'b1; gc = cyc; break; end
            @(negedge clk); #1;
        end
        @(negedge clk);
        rq_valid[r] = 1'b0;
    endtask

    task automatic wait_rsp(input int lim, output bit ok, output int rc);
        ok = 1'b0; rc = 0;
        for (int i = 0; i < lim; i++) begin
            if (rsp_valid) begin ok = 1'b1; rc = cyc; break; end
            @(negedge clk);
        end
    endtask

    task automatic finish_job();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b1; rq_valid = '0; rsp_ready = 1'b0; never_clear = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; rq_valid = 2'b11;
        repeat (3) @(negedge clk);
        #1;
        tests++; if (rq_ready !== 2'b00) begin fails++; $display("FAIL reset_rq_ready: got %b want 00", rq_ready); end
        tests++; if ({busy, rsp_valid, rsp_id, rsp_err} !== 5'b0) begin fails++;
            $display("FAIL reset_status: got busy=%b valid=%b id=%b err=%0d want all 0", busy, rsp_valid, rsp_id, rsp_err); end
        tests++; if ({m_sel, m_wen, m_addr, m_wdata} !== 45'b0) begin fails++;
            $display("FAIL reset_bus: got sel=%b wen=%h addr=%0d wdata=%h want all 0", m_sel, m_wen, m_addr, m_wdata); end
        rq_valid = '0; rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        int gc, rc; bit ok, ok2;
        logic [31:0] a6 = $urandom, a7 = $urandom;
        busy_cfg = 60;
        start_job(0, 8'd16, 8'd3, a6, a7, gc, ok);
        wait_rsp(300, ok2, rc);
        tests++; if (!(ok && ok2)) begin fails++; $display("FAIL single_handshake: got grant=%b rsp=%b want 1 1", ok, ok2); end
        tests++; if ({rsp_id, rsp_err} !== 3'b000) begin fails++; $display("FAIL single_rsp: got id=%b err=%0d want 0 0", rsp_id, rsp_err); end
        tests++; if (wr_addr.size() - wb != 4) begin fails++; $display("FAIL single_nwr: got %0d want 4", wr_addr.size() - wb); end
        else for (int k = 0; k < 4; k++) begin
            tests++; if ({wr_addr[wb+k], wr_data[wb+k]} !== exp_wr(k, 8'd16, 8'd3, a6, a7) || wr_cyc[wb+k] != wr_cyc[wb] + k) begin
                fails++; $display("FAIL single_wr%0d: got %0d:%h@%0d want %h@%0d", k, wr_addr[wb+k], wr_data[wb+k],
                                  wr_cyc[wb+k], exp_wr(k, 8'd16, 8'd3, a6, a7), wr_cyc[wb] + k); end
        end
        tests++; if (rd_cyc.size() == rb || (wr_addr.size() - wb == 4 && rd_cyc[rb] != wr_cyc[wb+3] + 1)) begin fails++;
            $display("FAIL single_first_poll: got %0d reads want first read right after CHNS write", rd_cyc.size() - rb); end
        finish_job();
    endtask

    task automatic test_rr();
        bit ok, found; int rc;
        apply_reset();
        rq_secn = {8'd16, 8'd16}; rq_chns = '0;
        rq_valid = 2'b11;
        #1;
        for (int k = 0; k < 4; k++) begin
            found = 1'b0;
            for (int i = 0; i < 50; i++) begin
                if (rq_ready != 0) begin found = 1'b1; break; end
                @(negedge clk); #1;
            end
            tests++; if (!found || rq_ready !== (k[0] ? 2'b10 : 2'b01)) begin fails++;
                $display("FAIL rr_grant%0d: got %b want %b", k, rq_ready, k[0] ? 2'b10 : 2'b01); end
            @(negedge clk); #1;
            tests++; if (rq_ready !== 2'b00) begin fails++; $display("FAIL rr_holdoff%0d: got %b want 00", k, rq_ready); end
            wait_rsp(50, ok, rc);
            tests++; if (!ok || rsp_id !== k[0]) begin fails++; $display("FAIL rr_id%0d: got %b want %b", k, rsp_id, k[0]); end
            finish_job();
            #1;
        end
        rq_valid = '0;
        @(negedge clk);
    endtask

    task automatic test_bad_secn();
        int gc, rc; bit ok, ok2;
        start_job(1, 8'd20, 8'd5, $urandom, $urandom, gc, ok);
        wait_rsp(10, ok2, rc);
        tests++; if (!(ok && ok2) || rc - gc > 3) begin fails++; $display("FAIL bad_secn_latency: got %0d cycles want <=3", rc - gc); end
        tests++; if ({rsp_id, rsp_err} !== 3'b101) begin fails++; $display("FAIL bad_secn_rsp: got id=%b err=%0d want 1 1", rsp_id, rsp_err); end
        tests++; if (wr_addr.size() != wb || rd_cyc.size() != rb) begin fails++;
            $display("FAIL bad_secn_bus: got %0d writes %0d reads want 0 0", wr_addr.size() - wb, rd_cyc.size() - rb); end
        finish_job();
    endtask

    task automatic test_timeout();
        int gc, rc; bit ok, ok2;
        never_clear = 1'b1;
        start_job(0, 8'd24, 8'd5, $urandom, $urandom, gc, ok);
        wait_rsp(500, ok2, rc);
        tests++; if (!(ok && ok2) || rsp_err !== 2'd2) begin fails++; $display("FAIL timeout_err: got %0d want 2", rsp_err); end
        tests++; if (rd_cyc.size() - rb != TMO + 1) begin fails++; $display("FAIL timeout_reads: got %0d want %0d", rd_cyc.size() - rb, TMO + 1); end
        never_clear = 1'b0;
        finish_job();
    endtask

    task automatic test_chns0_hold();
        int gc, rc, bad = 0; bit ok, ok2;
        start_job(1, 8'd32, 8'd0, $urandom, $urandom, gc, ok);
        wait_rsp(50, ok2, rc);
        tests++; if (!(ok && ok2) || {rsp_id, rsp_err} !== 3'b100) begin fails++; $display("FAIL chns0_rsp: got id=%b err=%0d want 1 0", rsp_id, rsp_err); end
        tests++; if (wr_addr.size() - wb != 3 || rd_cyc.size() != rb) begin fails++;
            $display("FAIL chns0_bus: got %0d writes %0d reads want 3 0", wr_addr.size() - wb, rd_cyc.size() - rb); end
        repeat (10) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || {rsp_id, rsp_err} !== 3'b100) bad++;
        end
        tests++; if (bad != 0) begin fails++; $display("FAIL chns0_hold: got %0d unstable cycles want 0", bad); end
        finish_job();
    endtask

    task automatic test_reset_mid();
        int gc, rc; bit ok, ok2, found = 1'b0;
        busy_cfg = 60;
        start_job(0, 8'd16, 8'd2, $urandom, $urandom, gc, ok);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (m_sel && m_wen == 4'h0) begin found = 1'b1; break; end
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk); #1;
        tests++; if (!found || {busy, rsp_valid, m_sel, m_wen, m_addr, m_wdata, rq_ready} !== 49'b0) begin fails++;
            $display("FAIL midreset_outputs: got busy=%b valid=%b sel=%b addr=%0d want all 0 (poll seen=%b)", busy, rsp_valid, m_sel, m_addr, found); end
        rst = 1'b0;
        wb = wr_addr.size(); rb = rd_cyc.size();
        repeat (5) @(negedge clk);
        tests++; if (wr_addr.size() != wb || rd_cyc.size() != rb || rsp_valid !== 1'b0) begin fails++;
            $display("FAIL midreset_quiet: got %0d writes %0d reads valid=%b want 0 0 0", wr_addr.size() - wb, rd_cyc.size() - rb, rsp_valid); end
        busy_cfg = 5;
        start_job(1, 8'd24, 8'd1, $urandom, $urandom, gc, ok);
        wait_rsp(100, ok2, rc);
        tests++; if (!(ok && ok2) || {rsp_id, rsp_err} !== 3'b100 || wr_addr.size() - wb != 4) begin fails++;
            $display("FAIL midreset_next_job: got id=%b err=%0d writes=%0d want 1 0 4", rsp_id, rsp_err, wr_addr.size() - wb); end
        finish_job();
    endtask

    task automatic test_random();
        int gc, rc, r, hold, n, sel; bit ok, ok2, nc;
        logic [7:0] sn, ch; logic [31:0] a6, a7;
        for (int j = 0; j < 24; j++) begin
            r = $urandom_range(0, 1);
            sel = $urandom_range(0, 4);
            sn = sel == 0 ? 8'd16 : sel == 1 ? 8'd24 : sel == 2 ? 8'd32 : 8'($urandom);
            ch = $urandom_range(0, 3) == 0 ? 8'd0 : 8'($urandom);
            a6 = $urandom; a7 = $urandom;
            nc = $urandom_range(0, 5) == 0;
            never_clear = nc;
            busy_cfg = $urandom_range(1, 30);
            hold = $urandom_range(0, 3);
            start_job(r, sn, ch, a6, a7, gc, ok);
            wait_rsp(500, ok2, rc);
            never_clear = 1'b0;
            tests++; if (!(ok && ok2) || rsp_id !== r[0] || rsp_err !== exp_err(sn, ch, nc)) begin fails++;
                $display("FAIL rand%0d_rsp: got id=%b err=%0d want %b %0d", j, rsp_id, rsp_err, r[0], exp_err(sn, ch, nc)); end
            n = exp_nwr(sn, ch);
            tests++; if (wr_addr.size() - wb != n) begin fails++; $display("FAIL rand%0d_nwr: got %0d want %0d", j, wr_addr.size() - wb, n); end
            else for (int k = 0; k < n; k++) begin
                tests++; if ({wr_addr[wb+k], wr_data[wb+k]} !== exp_wr(k, sn, ch, a6, a7)) begin fails++;
                    $display("FAIL rand%0d_wr%0d: got %0d:%h want %h", j, k, wr_addr[wb+k], wr_data[wb+k], exp_wr(k, sn, ch, a6, a7)); end
            end
            if (exp_err(sn, ch, nc) == 2'd2) begin
                tests++; if (rd_cyc.size() - rb != TMO + 1) begin fails++; $display("FAIL rand%0d_reads: got %0d want %0d", j, rd_cyc.size() - rb, TMO + 1); end
            end
            repeat (hold) @(negedge clk);
            finish_job();
        end
        tests++; if (bus_bad != 0) begin fails++; $display("FAIL idle_bus: got %0d bad bus cycles want 0", bus_bad); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_rr();
        test_bad_secn();
        test_timeout();
        test_chns0_hold();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
